nios_cpu_cpu_mult_combine: RTL and testbench



---
 rtl/nios_cpu_cpu_mult_combine.sv | 133 +++++++++++++
 tb/tb_nios_cpu_cpu_mult_combine.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/nios_cpu_cpu_mult_combine.sv
// Folds the three 16x16 partial products into the low 32-bit product word.
// Two-stage pipeline into an in-order result FIFO, with credit-based admission.
module nios_cpu_cpu_mult_combine #(
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_p1,
  input  logic [31:0]      in_p2,
  input  logic [31:0]      in_p3,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OW = $clog2(FIFO_DEPTH + 1);
  localparam logic [OW-1:0] OCC_FULL = OW'(FIFO_DEPTH);
  localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);
  localparam logic [OW-1:0] OCC_ONE  = OW'(1);

  typedef struct packed {
    logic [31:0]      result;
    logic [TAG_W-1:0] tag;
  } entry_t;

  logic             s1_vld_q;
  logic [31:0]      s1_p1_q;
  logic [16:0]      s1_cross_q;
  logic [TAG_W-1:0] s1_tag_q;

  logic             s2_vld_q;
  logic [31:0]      s2_res_q;
  logic [TAG_W-1:0] s2_tag_q;

  entry_t           mem_q [FIFO_DEPTH];
  logic [AW:0]      wr_q, rd_q;
  logic [OW-1:0]    occ_q, occ_d;

  logic             accept, pop;
  entry_t           head;
  logic             unused_hi;

  // The high halves of p2/p3 and the cross carry only reach the high product word.
  assign unused_hi = ^{in_p2[31:16], in_p3[31:16], s1_cross_q[16]};

  assign in_ready  = (occ_q != OCC_FULL) & ~flush;
  assign accept    = in_valid & in_ready;
  assign out_valid = (wr_q != rd_q);
  assign pop       = out_valid & out_ready & ~flush;
  assign busy      = (occ_q != '0);

  assign head       = mem_q[rd_q[AW-1:0]];
  assign out_result = out_valid ? head.result : '0;
  assign out_tag    = out_valid ? head.tag : '0;

  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (accept && !pop) begin
      occ_d = occ_q + OCC_ONE;
    end else if (pop && !accept) begin
      occ_d = occ_q - OCC_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_vld_q   <= 1'b0;
      s1_p1_q    <= '0;
      s1_cross_q <= '0;
      s1_tag_q   <= '0;
    end else if (flush) begin
      s1_vld_q <= 1'b0;
    end else begin
      s1_vld_q <= accept;
      if (accept) begin
        s1_p1_q    <= in_p1;
        s1_cross_q <= {1'b0, in_p2[15:0]} + {1'b0, in_p3[15:0]};
        s1_tag_q   <= in_tag;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_vld_q <= 1'b0;
      s2_res_q <= '0;
      s2_tag_q <= '0;
    end else if (flush) begin
      s2_vld_q <= 1'b0;
    end else begin
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        s2_res_q <= s1_p1_q + {s1_cross_q[15:0], 16'h0000};
        s2_tag_q <= s1_tag_q;
      end
    end
  end

  // Stage 2 never stalls: occupancy admission guarantees a free FIFO slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
      if (flush) begin
        wr_q <= '0;
        rd_q <= '0;
      end else begin
        if (s2_vld_q) wr_q <= wr_q + PTR_ONE;
        if (pop)      rd_q <= rd_q + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (s2_vld_q && !flush) begin
      mem_q[wr_q[AW-1:0]] <= '{result: s2_res_q, tag: s2_tag_q};
    end
  end

endmodule

// File: tb/tb_nios_cpu_cpu_mult_combine.sv
// Directed bench for the partial-product combiner: latency, wrap, streaming,
// backpressure, flush and asynchronous reset.
module tb_nios_cpu_cpu_mult_combine;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] in_p1, in_p2, in_p3, out_result;
  logic [4:0]  in_tag, out_tag;

  int n_checks = 0;
  int n_errors = 0;

  nios_cpu_cpu_mult_combine #(.FIFO_DEPTH(4), .TAG_W(5)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_p1(in_p1), .in_p2(in_p2), .in_p3(in_p3), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [4:0] t);
    in_valid = v;
    in_p1    = a;
    in_p2    = b;
    in_p3    = c;
    in_tag   = t;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, '0, '0, '0, '0);
    cyc(); cyc();
    reset = 1'b0;
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_tag", {27'b0, out_tag}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    cyc();

    // Basic product: 0x00010002 * 0x00030004
    drive(1'b1, 32'h00000008, 32'h00000006, 32'h00000004, 5'd3);
    cyc();
    drive(1'b0, '0, '0, '0, '0);
    chk("basic_valid_n1", {31'b0, out_valid}, 32'd0);
    chk("basic_busy", {31'b0, busy}, 32'd1);
    cyc();
    chk("basic_valid_n2", {31'b0, out_valid}, 32'd0);
    cyc();
    chk("basic_valid", {31'b0, out_valid}, 32'd1);
    chk("basic_result", out_result, 32'h000A0008);
    chk("basic_tag", {27'b0, out_tag}, 32'd3);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("basic_popped", {31'b0, out_valid}, 32'd0);
    chk("basic_idle", {31'b0, busy}, 32'd0);

    // Wrap: 0xFFFFFFFF squared, then a vector whose cross sum carries only into bit 16
    drive(1'b1, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 5'd21);
    cyc();
    drive(1'b1, 32'h00000000, 32'h1234FFFF, 32'hABCD0001, 5'd22);
    cyc();
    drive(1'b0, '0, '0, '0, '0);
    cyc();
    chk("wrap_result", out_result, 32'h00000001);
    chk("wrap_tag", {27'b0, out_tag}, 32'd21);
    out_ready = 1'b1;
    cyc();
    chk("wrap2_result", out_result, 32'h00000000);
    chk("wrap2_tag", {27'b0, out_tag}, 32'd22);
    chk("wrap2_valid", {31'b0, out_valid}, 32'd1);
    cyc();
    chk("wrap_drained", {31'b0, busy}, 32'd0);

    // Streaming: 8 back-to-back sets, consumer always ready
    for (int c = 0; c < 11; c++) begin
      if (c < 8) begin
        drive(1'b1, 32'(c), 32'h0, 32'h0, 5'(c));
        chk("stream_in_ready", {31'b0, in_ready}, 32'd1);
      end else begin
        drive(1'b0, '0, '0, '0, '0);
      end
      if (c >= 3) begin
        chk("stream_valid", {31'b0, out_valid}, 32'd1);
        chk("stream_tag", {27'b0, out_tag}, 32'(c - 3));
        chk("stream_result", out_result, 32'(c - 3));
      end else begin
        chk("stream_lead_valid", {31'b0, out_valid}, 32'd0);
      end
      cyc();
    end
    chk("stream_idle", {31'b0, busy}, 32'd0);

    // Backpressure: 5 offered with consumer stalled, only 4 admitted
    out_ready = 1'b0;
    begin
      int k;
      k = 0;
      for (int c = 0; c < 6; c++) begin
        drive(1'b1, 32'h100 + 32'(k), 32'h0, 32'h0, 5'd10 + 5'(k));
        chk("bp_in_ready", {31'b0, in_ready}, (c < 4) ? 32'd1 : 32'd0);
        cyc();
        if (c < 4) k++;
      end
    end
    chk("bp_full_ready", {31'b0, in_ready}, 32'd0);
    chk("bp_head_valid", {31'b0, out_valid}, 32'd1);
    chk("bp_head_tag", {27'b0, out_tag}, 32'd10);
    chk("bp_head_result", out_result, 32'h100);
    out_ready = 1'b1;
    cyc();
    chk("bp_ready_back", {31'b0, in_ready}, 32'd1);
    chk("bp_tag11", {27'b0, out_tag}, 32'd11);
    cyc();
    drive(1'b0, '0, '0, '0, '0);
    chk("bp_tag12", {27'b0, out_tag}, 32'd12);
    cyc();
    chk("bp_tag13", {27'b0, out_tag}, 32'd13);
    cyc();
    chk("bp_tag14", {27'b0, out_tag}, 32'd14);
    chk("bp_result14", out_result, 32'h104);
    cyc();
    chk("bp_drained_valid", {31'b0, out_valid}, 32'd0);
    chk("bp_drained_busy", {31'b0, busy}, 32'd0);

    // Flush with 3 in flight and a simultaneous input
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 32'hDEAD0000 + 32'(c), 32'h0, 32'h0, 5'd20 + 5'(c));
      cyc();
    end
    flush = 1'b1;
    drive(1'b1, 32'hBAD0BAD0, 32'h0, 32'h0, 5'd7);
    #1;
    chk("flush_in_ready", {31'b0, in_ready}, 32'd0);
    cyc();
    flush = 1'b0;
    drive(1'b0, '0, '0, '0, '0);
    chk("flush_valid", {31'b0, out_valid}, 32'd0);
    chk("flush_busy", {31'b0, busy}, 32'd0);
    chk("flush_result", out_result, 32'd0);
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cyc();
      chk("flush_no_stale", {31'b0, out_valid}, 32'd0);
    end
    out_ready = 1'b0;
    drive(1'b1, 32'h00000011, 32'h00000022, 32'h00000033, 5'd9);
    cyc();
    drive(1'b0, '0, '0, '0, '0);
    cyc(); cyc();
    chk("post_flush_valid", {31'b0, out_valid}, 32'd1);
    chk("post_flush_result", out_result, 32'h00550011);
    chk("post_flush_tag", {27'b0, out_tag}, 32'd9);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;

    // Asynchronous reset with the FIFO full
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 32'h5000 + 32'(c), 32'h0, 32'h0, 5'd1 + 5'(c));
      cyc();
    end
    drive(1'b0, '0, '0, '0, '0);
    cyc(); cyc();
    chk("ar_full_valid", {31'b0, out_valid}, 32'd1);
    chk("ar_full_ready", {31'b0, in_ready}, 32'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_valid", {31'b0, out_valid}, 32'd0);
    chk("ar_busy", {31'b0, busy}, 32'd0);
    chk("ar_result", out_result, 32'd0);
    chk("ar_tag", {27'b0, out_tag}, 32'd0);
    #2;
    reset = 1'b0;
    cyc();
    chk("ar_in_ready", {31'b0, in_ready}, 32'd1);
    chk("ar_still_idle", {31'b0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
